// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Purpose  : Framed byte-stream loader that programs the IMEM and holds the
//            core in reset until the image is written and checksum-verified.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        start,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [16:0] c_depth = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [7:0]  r_len_lo;
  logic [15:0] r_len;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [7:0]  r_xor;
  logic [15:0] r_word_idx;
  logic        r_wr_en;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_rearm;
  logic        w_done;
  logic        w_error;
  logic        w_core_hold;
  logic [15:0] w_len_full;
  logic        w_last_byte;
  logic        w_last_word;

  assign w_len_full  = {in_data, r_len_lo};
  assign w_last_byte = (r_byte_cnt == 2'd3);
  // The previous word's write has always retired before the next 4th byte,
  // so the word index equals the number of the word currently being received.
  assign w_last_word = (r_word_idx == (r_len - 16'd1));
  assign w_accept    = in_valid && w_in_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and decoded outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_core_hold  = 1'b1;
    w_rearm      = 1'b0;
    case (r_state)
      S_LEN0: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_next = S_LEN1;
      end
      S_LEN1: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if ({1'b0, w_len_full} > c_depth) begin
            w_state_next = S_ERR;
          end else if (w_len_full == 16'd0) begin
            w_state_next = S_CSUM;
          end else begin
            w_state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        w_in_ready = 1'b1;
        if (in_valid && w_last_byte && w_last_word) w_state_next = S_CSUM;
      end
      S_CSUM: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = (in_data == r_xor) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_core_hold = 1'b0;
        if (start) begin
          w_rearm      = 1'b1;
          w_state_next = S_LEN0;
        end
      end
      S_ERR: begin
        w_error = 1'b1;
        if (start) begin
          w_rearm      = 1'b1;
          w_state_next = S_LEN0;
        end
      end
      default: begin
        w_state_next = S_LEN0;
      end
    endcase
  end

  // Datapath: length capture, word assembly, running XOR and write strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len_lo   <= 8'd0;
      r_len      <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_xor      <= 8'd0;
      r_word_idx <= 16'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= 32'd0;
      r_wr_data  <= 32'd0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_rearm) begin
        r_xor      <= 8'd0;
        r_word_idx <= 16'd0;
        r_byte_cnt <= 2'd0;
      end else begin
        if (r_wr_en) r_word_idx <= r_word_idx + 16'd1;
        if (w_accept) begin
          if (r_state != S_CSUM) r_xor <= r_xor ^ in_data;
          case (r_state)
            S_LEN0: r_len_lo <= in_data;
            S_LEN1: r_len    <= w_len_full;
            S_DATA: begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              if (w_last_byte) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= {16'd0, r_word_idx};
                r_wr_data <= {in_data, r_shift};
              end else begin
                r_shift <= {in_data, r_shift[23:8]};
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign in_ready     = w_in_ready;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign core_hold    = w_core_hold;
  assign done         = w_done;
  assign error        = w_error;
  assign words_loaded = r_word_idx;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Purpose  : Directed self-checking bench for imem_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        start = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          wc[$];

  imem_loader #(.DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .start        (start),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
      wc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap, output int stamp);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_before_byte", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    stamp    = cyc;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int base, input int s0, input int s1);
    chk({tag, "_write_count"}, wa.size(), base + 2);
    if (wa.size() >= base + 2) begin
      chk({tag, "_addr0"}, wa[base], 32'd0);
      chk({tag, "_data0"}, wd[base], 32'h00500093);
      chk({tag, "_time0"}, wc[base], s0);
      chk({tag, "_addr1"}, wa[base+1], 32'd1);
      chk({tag, "_data1"}, wd[base+1], 32'h00108113);
      chk({tag, "_time1"}, wc[base+1], s1);
    end
  endtask

  initial begin
    logic [7:0] frame [11];
    int hs [11];
    int base;
    int dummy;

    frame[0] = 8'h02; frame[1] = 8'h00; frame[2] = 8'h93; frame[3] = 8'h00;
    frame[4] = 8'h50; frame[5] = 8'h00; frame[6] = 8'h13; frame[7] = 8'h81;
    frame[8] = 8'h10; frame[9] = 8'h00; frame[10] = 8'h43;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_words", {16'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Normal load, back-to-back bytes
    base = wa.size();
    for (int i = 0; i < 10; i++) send(frame[i], 0, hs[i]);
    chk("norm_hold_before_csum", {31'd0, core_hold}, 32'd1);
    chk("norm_done_before_csum", {31'd0, done}, 32'd0);
    send(frame[10], 0, hs[10]);
    chk("norm_done", {31'd0, done}, 32'd1);
    chk("norm_core_hold", {31'd0, core_hold}, 32'd0);
    chk("norm_in_ready", {31'd0, in_ready}, 32'd0);
    chk("norm_error", {31'd0, error}, 32'd0);
    chk("norm_words", {16'd0, words_loaded}, 32'd2);
    check_writes("norm", base, hs[5], hs[9]);

    // Re-arm from DONE
    pulse_start();
    chk("rearm_done", {31'd0, done}, 32'd0);
    chk("rearm_core_hold", {31'd0, core_hold}, 32'd1);
    chk("rearm_words", {16'd0, words_loaded}, 32'd0);
    chk("rearm_in_ready", {31'd0, in_ready}, 32'd1);

    // Zero-length frame
    base = wa.size();
    send(8'h00, 0, dummy);
    send(8'h00, 0, dummy);
    send(8'h00, 0, dummy);
    repeat (2) @(posedge clk);
    #1;
    chk("zero_writes", wa.size(), base);
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_words", {16'd0, words_loaded}, 32'd0);
    pulse_start();

    // Bad checksum
    base = wa.size();
    for (int i = 0; i < 10; i++) send(frame[i], 0, hs[i]);
    send(8'h44, 0, hs[10]);
    chk("badcs_error", {31'd0, error}, 32'd1);
    chk("badcs_done", {31'd0, done}, 32'd0);
    chk("badcs_core_hold", {31'd0, core_hold}, 32'd1);
    chk("badcs_in_ready", {31'd0, in_ready}, 32'd0);
    check_writes("badcs", base, hs[5], hs[9]);

    // Start coinciding with a valid byte: that byte must not be consumed
    in_valid = 1'b1;
    in_data  = 8'h02;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    chk("rearm_err_error", {31'd0, error}, 32'd0);
    chk("rearm_err_in_ready", {31'd0, in_ready}, 32'd1);
    base = wa.size();
    send(8'h00, 0, dummy);
    send(8'h00, 0, dummy);
    send(8'h00, 0, dummy);
    chk("nobyte_done", {31'd0, done}, 32'd1);
    chk("nobyte_writes", wa.size(), base);
    pulse_start();

    // Oversize count
    base = wa.size();
    send(8'h01, 0, dummy);
    send(8'h01, 0, dummy);
    chk("over_error", {31'd0, error}, 32'd1);
    chk("over_in_ready", {31'd0, in_ready}, 32'd0);
    chk("over_core_hold", {31'd0, core_hold}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("over_writes", wa.size(), base);
    pulse_start();

    // Gaps between bytes
    base = wa.size();
    for (int i = 0; i < 11; i++) send(frame[i], int'($urandom_range(0, 5)), hs[i]);
    chk("gap_done", {31'd0, done}, 32'd1);
    chk("gap_words", {16'd0, words_loaded}, 32'd2);
    check_writes("gap", base, hs[5], hs[9]);
    pulse_start();

    // Reset mid-frame, then a full frame
    base = wa.size();
    for (int i = 0; i < 5; i++) send(frame[i], 0, hs[i]);
    reset = 1'b1;
    #1;
    chk("midrst_core_hold", {31'd0, core_hold}, 32'd1);
    chk("midrst_words", {16'd0, words_loaded}, 32'd0);
    chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_partial_writes", wa.size(), base);
    for (int i = 0; i < 11; i++) send(frame[i], 0, hs[i]);
    chk("midrst_done", {31'd0, done}, 32'd1);
    chk("midrst_words_final", {16'd0, words_loaded}, 32'd2);
    check_writes("midrst", base, hs[5], hs[9]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
